// File: rtl/clock_pkg.sv
// Shared types and constants for the clock ratio detector.
package clock_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StTrack,
    StLocked
  } crd_state_t;

  // Shortest period (clk cycles) the detector accepts; anything shorter is a glitch.
  localparam int unsigned MinPeriod = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with history flop and registered rising-edge strobe.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic edge_o
);

  logic sync1_q, sync2_q, sync3_q, edge_q;

  // Synchronize the async input and register a strobe on its rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/clock_ratio_detector.sv
// Measures the period of a slow asynchronous clock in clk cycles and locks onto it.
module clock_ratio_detector
  import clock_pkg::*;
#(
  parameter int unsigned MaxRatio  = 1024,
  parameter int unsigned LockCount = 4,
  parameter int unsigned Tol       = 1,
  localparam int unsigned Cw = $clog2(MaxRatio + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_i,
  output logic          edge_o,
  output logic [Cw-1:0] ratio_o,
  output logic          locked_o,
  output logic          timeout_o
);

  localparam int unsigned Dw = Cw + 1;
  localparam int unsigned Mw = $clog2(LockCount + 1);

  localparam logic [Cw-1:0] SatVal  = Cw'(MaxRatio);
  localparam logic [Cw-1:0] MinVal  = Cw'(MinPeriod);
  localparam logic [Dw-1:0] TolVal  = Dw'(Tol);
  localparam logic [Mw-1:0] LastCnt = Mw'(LockCount - 1);

  crd_state_t    state_q, state_d;
  logic [Cw-1:0] cnt_q, cnt_d;
  logic [Cw-1:0] ref_q, ref_d;
  logic [Mw-1:0] match_q, match_d;
  logic [Cw-1:0] ratio_q, ratio_d;
  logic          locked_q, locked_d;
  logic          timeout_q, timeout_d;

  logic          edge_s;
  logic          saturated;
  logic          glitch;
  logic          match;
  logic [Dw-1:0] diff;
  logic [Dw-1:0] abs_diff;

  sync_edge_detect u_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(clk_i),
    .edge_o (edge_s)
  );

  // Period comparison against the reference; the extra bit carries the sign.
  always_comb begin
    diff      = {1'b0, cnt_q} - {1'b0, ref_q};
    abs_diff  = diff[Dw-1] ? (~diff + Dw'(1)) : diff;
    match     = (abs_diff <= TolVal);
    saturated = (cnt_q == SatVal);
    glitch    = (cnt_q < MinVal);
  end

  // Period counter: restart at 1 on each edge, otherwise count up and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_s) begin
      cnt_d = Cw'(1);
    end else if (!saturated) begin
      cnt_d = cnt_q + Cw'(1);
    end
  end

  // Acquisition FSM; an edge always takes precedence over saturation.
  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    match_d   = match_q;
    ratio_d   = ratio_q;
    locked_d  = locked_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (edge_s) begin
          state_d = StMeasure;
          match_d = '0;
        end
      end

      StMeasure, StTrack, StLocked: begin
        if (edge_s) begin
          if (glitch) begin
            // Too fast to be a valid input clock: drop lock, keep last ratio.
            state_d  = StIdle;
            locked_d = 1'b0;
            match_d  = '0;
          end else if (state_q == StMeasure) begin
            ref_d   = cnt_q;
            match_d = '0;
            state_d = StTrack;
          end else if (match) begin
            if (state_q == StTrack) begin
              match_d = match_q + Mw'(1);
              if (match_q == LastCnt) begin
                ratio_d  = ref_q;
                locked_d = 1'b1;
                state_d  = StLocked;
              end
            end
          end else begin
            ref_d    = cnt_q;
            match_d  = '0;
            locked_d = 1'b0;
            state_d  = StTrack;
          end
        end else if (saturated) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          ratio_d   = '0;
          match_d   = '0;
          state_d   = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ref_q     <= '0;
      match_q   <= '0;
      ratio_q   <= '0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_q     <= ref_d;
      match_q   <= match_d;
      ratio_q   <= ratio_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign edge_o    = edge_s;
  assign ratio_o   = ratio_q;
  assign locked_o  = locked_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Directed bench for clock_ratio_detector; clk_i is driven on clk negedges.
module tb_clock_ratio_detector;

  localparam int unsigned Cw = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_i;
  logic          edge_o;
  logic [Cw-1:0] ratio_o;
  logic          locked_o;
  logic          timeout_o;

  int errors = 0;
  int checks = 0;
  int since_rise = 10000;
  int n_edges = 0;
  int n_to = 0;
  int to_at = 0;

  clock_ratio_detector dut (
    .clk      (clk),
    .reset    (reset),
    .clk_i    (clk_i),
    .edge_o   (edge_o),
    .ratio_o  (ratio_o),
    .locked_o (locked_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clk cycle, sampling the strobes at the negedge.
  task automatic tick();
    @(negedge clk);
    since_rise++;
    if (edge_o === 1'b1) n_edges++;
    if (timeout_o === 1'b1) begin
      n_to++;
      to_at = since_rise;
    end
  endtask

  // Raise clk_i m cycles after the previous rise, high for 1 cycle, return post cycles later.
  task automatic edge_after(input int m, input int post);
    while (since_rise < m) tick();
    clk_i = 1'b1;
    since_rise = 0;
    tick();
    clk_i = 1'b0;
    for (int i = 1; i < post; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    since_rise = 10000;
    n_edges = 0;
    n_to = 0;
  endtask

  // Acquire from IDLE: not locked after edge 5, locked with ratio m after edge 6.
  task automatic acquire(input int m, input string tag);
    for (int i = 1; i <= 6; i++) begin
      edge_after(m, 4);
      if (i == 5) check({tag, "_unlocked_e5"}, int'(locked_o), 0);
    end
    check({tag, "_locked_e6"}, int'(locked_o), 1);
    check({tag, "_ratio"}, int'(ratio_o), m);
  endtask

  initial begin
    reset = 1'b1;
    clk_i = 1'b0;
    #2;
    check("rst_edge", int'(edge_o), 0);
    check("rst_ratio", int'(ratio_o), 0);
    check("rst_locked", int'(locked_o), 0);
    check("rst_timeout", int'(timeout_o), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Steady M=8.
    acquire(8, "m8");
    check("m8_edges", n_edges, 6);
    check("m8_no_timeout", n_to, 0);

    // Stop clk_i while locked: one timeout pulse, lock and ratio cleared.
    for (int i = 0; i < 1300; i++) tick();
    check("to_count", n_to, 1);
    check("to_latency_ok", int'(to_at >= 1026 && to_at <= 1030), 1);
    check("to_locked", int'(locked_o), 0);
    check("to_ratio", int'(ratio_o), 0);
    n_to = 0;
    acquire(8, "to_relock");
    check("to_relock_no_timeout", n_to, 0);

    // Asynchronous reset mid-lock.
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_locked", int'(locked_o), 0);
    check("mid_rst_ratio", int'(ratio_o), 0);
    check("mid_rst_edge", int'(edge_o), 0);
    check("mid_rst_timeout", int'(timeout_o), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    since_rise = 10000;
    acquire(8, "post_rst");

    // Odd period, asymmetric duty.
    do_reset();
    acquire(7, "m7");
    check("m7_edges", n_edges, 6);

    // Tolerance window while locked, then a real change.
    do_reset();
    acquire(8, "tol");
    edge_after(9, 4);
    check("tol_p9_locked", int'(locked_o), 1);
    edge_after(7, 4);
    check("tol_p7_locked", int'(locked_o), 1);
    edge_after(8, 4);
    check("tol_p8_locked", int'(locked_o), 1);
    check("tol_ratio_hold", int'(ratio_o), 8);
    edge_after(10, 4);
    check("p10_unlocked", int'(locked_o), 0);
    check("p10_ratio_hold", int'(ratio_o), 8);
    for (int i = 1; i <= 4; i++) begin
      edge_after(10, 4);
      if (i == 3) check("p10_not_yet", int'(locked_o), 0);
    end
    check("p10_relocked", int'(locked_o), 1);
    check("p10_ratio", int'(ratio_o), 10);

    // Glitch period of 3 while locked at 10.
    edge_after(10, 1);
    edge_after(3, 4);
    check("glitch_unlocked", int'(locked_o), 0);
    check("glitch_ratio_hold", int'(ratio_o), 10);
    acquire(8, "glitch_relock");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
